// File: rtl/rs232_pkg.sv
// Shared constants, state codes and frame helpers for the RS-232 frame link.
// Imported by the parser and the frame controller.
package rs232_pkg;

  localparam logic [7:0] STX    = 8'h02;
  localparam logic [7:0] ETX    = 8'h03;
  localparam logic [7:0] RSV_TX = 8'h00;
  localparam int         FRAME_LEN = 8;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_CMD  = 3'd1;
  localparam logic [2:0] P_DATA = 3'd2;
  localparam logic [2:0] P_RSV  = 3'd3;
  localparam logic [2:0] P_ETX  = 3'd4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_RD   = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_SEND = 2'd3;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] word;
  } frame_t;

  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  cmd,
    input logic [31:0] word
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = STX;
      3'd1:    b = cmd;
      3'd2:    b = word[7:0];
      3'd3:    b = word[15:8];
      3'd4:    b = word[23:16];
      3'd5:    b = word[31:24];
      3'd6:    b = RSV_TX;
      default: b = ETX;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rs232_frame_parser.sv
// Host command frame parser with inter-byte timeout.
// Emits a one-cycle commit strobe with the assembled frame on a valid ETX.
module rs232_frame_parser
  import rs232_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       commit,
  output frame_t     frame,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] tcnt;
  logic          timeout;
  logic          at_etx;

  assign at_etx  = rx_valid && (state == P_ETX);
  assign timeout = !rx_valid && (state != P_IDLE)
                && (tcnt == CW'(TIMEOUT_CYC));
  assign commit  = at_etx && (rx_data == ETX);
  assign err     = timeout || (at_etx && (rx_data != ETX));

  // Saturates so a long idle line never wraps into a false timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (rx_valid) begin
      tcnt <= '0;
    end else if (tcnt != CW'(TIMEOUT_CYC)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= P_IDLE;
      idx   <= '0;
      frame <= '0;
    end else if (timeout) begin
      state <= P_IDLE;
    end else if (rx_valid) begin
      unique case (1'b1)
        state == P_IDLE: begin
          if (rx_data == STX) state <= P_CMD;
        end
        state == P_CMD: begin
          frame.cmd <= rx_data;
          idx       <= '0;
          state     <= P_DATA;
        end
        state == P_DATA: begin
          frame.word[{idx, 3'b000} +: 8] <= rx_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= P_RSV;
        end
        state == P_RSV: begin
          state <= P_ETX;
        end
        default: begin
          state <= P_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rs232_frame_ctrl.sv
// Frame controller: commits writes to word RAM, queues one read and
// returns it as an 8-byte response while publishing it to Port B.
module rs232_frame_ctrl
  import rs232_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              port_b_load,
  output logic [31:0]       port_b_word,
  output logic              err
);

  logic   p_commit;
  logic   p_err;
  frame_t p_frame;

  rs232_frame_parser #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_parser (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .commit  (p_commit),
    .frame   (p_frame),
    .err     (p_err)
  );

  logic wr_commit;
  logic rd_commit;

  assign wr_commit = p_commit && p_frame.cmd[7];
  assign rd_commit = p_commit && !p_frame.cmd[7];

  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q <= wr_commit;
      if (wr_commit) begin
        wr_addr_q <= p_frame.cmd[ADDR_W-1:0];
        wr_data_q <= p_frame.word;
      end
    end
  end

  logic [1:0]  rsp;
  logic [2:0]  tx_idx;
  logic [7:0]  snd_cmd;
  logic [31:0] rd_word;
  logic        slot_full;
  logic [7:0]  slot_cmd;
  logic        slot_free;
  logic        slot_take;
  logic        ovf;
  logic        tx_hs;

  assign slot_free = (rsp == R_WAIT);
  assign slot_take = rd_commit && (!slot_full || slot_free);
  assign ovf       = rd_commit && slot_full && !slot_free;
  assign tx_hs     = tx_valid && tx_ready;

  // A read freed in R_WAIT makes room for a read committing that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full <= 1'b0;
      slot_cmd  <= '0;
    end else if (slot_take) begin
      slot_full <= 1'b1;
      slot_cmd  <= p_frame.cmd;
    end else if (slot_free) begin
      slot_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp     <= R_IDLE;
      tx_idx  <= '0;
      snd_cmd <= '0;
      rd_word <= '0;
    end else begin
      unique case (1'b1)
        rsp == R_IDLE: begin
          if (slot_full) rsp <= R_RD;
        end
        rsp == R_RD: begin
          if (!wr_q) rsp <= R_WAIT;
        end
        rsp == R_WAIT: begin
          rd_word <= ram_rdata;
          snd_cmd <= slot_cmd;
          tx_idx  <= '0;
          rsp     <= R_SEND;
        end
        default: begin
          if (tx_hs) begin
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == 3'(FRAME_LEN - 1)) rsp <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= p_err || ovf;
  end

  // A pending write owns the RAM port; the read stays in R_RD meanwhile.
  assign ram_en    = wr_q || (rsp == R_RD);
  assign ram_we    = wr_q;
  assign ram_addr  = wr_q ? wr_addr_q
                   : (rsp == R_RD) ? slot_cmd[ADDR_W-1:0] : '0;
  assign ram_wdata = wr_q ? wr_data_q : '0;

  assign port_b_load = slot_free;
  assign port_b_word = slot_free ? ram_rdata : rd_word;

  assign tx_valid = (rsp == R_SEND);
  assign tx_data  = tx_valid ? frame_byte(tx_idx, snd_cmd, rd_word) : '0;

endmodule

// File: doc/rs232_frame_ctrl.md
# rs232_frame_ctrl

Frame-level controller between the UART byte receiver/transmitter and the 32-bit word RAM in the RS-232 link. It parses the fixed 8-byte host command frame, commits write commands into the RAM, and schedules read commands into framed 8-byte responses on the UART transmitter. It also publishes each read-back word to the board Port B latch.

## Interface
- ADDR_W, 7: RAM word-address width; equals cmd[6:0].
- TIMEOUT_CYC, 1_000_000: maximum idle cycles between bytes inside a frame.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte offered to UART transmitter.
- tx_data  out  8  byte offered.
- tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  write enable (qualified by ram_en).
- ram_addr  out  ADDR_W  word address.
- ram_wdata  out  32  write word.
- ram_rdata  in  32  read word, valid the cycle after a read strobe.
- port_b_load  out  1  one-cycle pulse; port_b_word valid.
- port_b_word  out  32  last word read from RAM.
- err  out  1  one-cycle pulse on any dropped frame.

## Operation
- Frame: 0x02, CMD, D0, D1, D2, D3, RSV, 0x03. CMD[7]=1 write, CMD[7]=0 read; CMD[6:0] = address. RSV is ignored. Word = {D3,D2,D1,D0}.
- Parser states: P_IDLE, P_CMD, P_DATA (2-bit byte counter), P_RSV, P_ETX.
  - P_IDLE: a byte other than 0x02 is discarded silently.
  - P_ETX: a byte other than 0x03 drops the frame, pulses err and returns to P_IDLE.
- Write commit: on a valid ETX, ram_en=ram_we=1 with addr/wdata for exactly one cycle. No response frame.
- Read commit: a valid ETX of a read frame loads a single-entry pending slot {cmd, addr}.
  - If the slot is already full, the new read is dropped and err pulses.
  - The parser never stalls.
- Responder states: R_IDLE, R_RD, R_WAIT, R_SEND (3-bit index).
  - R_IDLE: slot full -> R_RD.
  - R_RD: ram_en=1, ram_we=0. On a conflict with a write commit in the same cycle, the write wins and R_RD retries the next cycle.
  - R_WAIT: capture ram_rdata, pulse port_b_load, free the slot.
  - R_SEND: emit 0x02, CMD, D0..D3, 0x00, 0x03, advancing on each tx handshake. After byte 7 -> R_IDLE.
- A new read may be queued while R_SEND is active.
- Timeout: a counter clears on every rx_valid. If it reaches TIMEOUT_CYC while the parser is not in P_IDLE, the parser returns to P_IDLE and err pulses. The responder is unaffected.

## Timing
- Reset values: tx_valid=0, tx_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, port_b_load=0, port_b_word=0, err=0. Parser P_IDLE, responder R_IDLE, slot empty.
- Reset mid-frame or mid-response abandons both immediately; no partial RAM write.
- Write latency: ram_we asserts the cycle after the ETX rx_valid.
- Read latency without conflict:
  - ETX at cycle N: slot full at N+1, ram_en at N+2.
  - port_b_load at N+3.
  - tx_valid with 0x02 at N+4.
- tx_valid/tx_data stay stable until handshake; tx_valid never drops without a handshake except on reset.
- Simultaneous read-slot free (R_WAIT) and new read commit in the same cycle: the slot is accepted, no err.
- Address wraps naturally within ADDR_W.

## Structure
- Shared package rs232_pkg: STX=0x02, ETX=0x03, RSV_TX=0x00, frame length 8, parser and responder state enums.
- Sub-module rs232_frame_parser: parser FSM plus timeout, emitting a commit strobe with {cmd, word}. The top holds the slot, arbitration and responder.

## Test plan
- Write: 02,FF,04,08,16,32,00,03 -> one cycle ram_we=1, ram_addr=0x7F, ram_wdata=0x32160804. No tx_valid.
- Read-back: a following 02,7F,00,00,00,00,00,03 -> port_b_word=0x32160804 pulsed, then TX 02,7F,04,08,16,32,00,03. Hold tx_ready low for random gaps; bytes must be unchanged.
- Bad ETX: 02,FE,0A,0B,0C,0D,00,04 -> err pulse, no ram_we. The next good frame is accepted.
- Timeout: 02,FE,0A then silence TIMEOUT_CYC cycles -> err pulse, parser idle. A later full frame writes 0x0D0C0B0A to 0x7E.
- Overflow: three read frames back-to-back with tx_ready=0 -> the first is sending, the second is pending, the third gives err. Exactly two responses are sent.
- Reset mid-response after byte 3 -> tx_valid=0 the next cycle; a following read responds cleanly from 0x02.
